fifo_sync_ram_ctrl: RTL
=======================

// Module: fifo_sync_ram_ctrl
// PURPOSE
//  Single-clock FIFO controller that sequences the dual-port LSRAM wrapper (W_ADDR/W_EN, R_ADDR/R_EN).
//  Owns the write/read pointers, the occupancy count, the status flags and the read-data-valid pipeline.
//  Sits between the digitizer sample producer and the readout consumer; the RAM itself stays external.
// PARAMETERS
//  DEPTH      128  words in RAM; must be a power of 2
//  AWIDTH     7    RAM address width; must equal log2(DEPTH)
//  RD_LAT     2    RAM read latency in cycles; 1 = non-pipelined, 2 = pipelined RDATA
//  AFULL_TH   120  AFULL asserts when count >= AFULL_TH
//  AEMPTY_TH  8    AEMPTY asserts when count <= AEMPTY_TH
// PORTS
//  CLOCK      in   1         single clock; RAM WCLOCK and RCLOCK both tie to it
//  RESET      in   1         asynchronous, active-high reset
//  WE         in   1         write request from producer
//  RE         in   1         read request from consumer
//  RAM_WADDR  out  AWIDTH    RAM write address (= wptr)
//  RAM_WEN    out  1         RAM write enable
//  RAM_RADDR  out  AWIDTH    RAM read address (= rptr)
//  RAM_REN    out  1         RAM read enable
//  DVLD       out  1         RAM RDATA valid this cycle
//  FULL       out  1         count == DEPTH
//  EMPTY      out  1         count == 0
//  AFULL      out  1         almost full
//  AEMPTY     out  1         almost empty
//  WRCNT      out  AWIDTH+1  occupancy, 0..DEPTH
//  OVERFLOW   out  1         1-cycle pulse: write attempted while full
//  UNDERFLOW  out  1         1-cycle pulse: read attempted while empty
// BEHAVIOUR
//  Reset (async assert, sync release) forces:
//    - wptr = rptr = 0, WRCNT = 0, EMPTY = 1, AEMPTY = 1
//    - FULL = AFULL = OVERFLOW = UNDERFLOW = DVLD = 0
//    - DVLD pipeline cleared; in-flight reads are dropped and produce no DVLD
//  Accept rules:
//    - wr_ok = WE & ~FULL; rd_ok = RE & ~EMPTY (FULL/EMPTY are the registered flags)
//    - RAM_WEN = wr_ok, RAM_REN = rd_ok, combinational
//    - RAM_WADDR/RAM_RADDR driven directly from the registered pointers
//  Pointers: +1 on accept; wrap DEPTH-1 -> 0 by natural AWIDTH overflow.
//  Count: next = WRCNT + wr_ok - rd_ok.
//    - Simultaneous accepted write and read: count unchanged, both pointers advance.
//  Boundary cases:
//    - Full: WE&RE -> only the read is accepted; count drops to DEPTH-1.
//    - Empty: WE&RE -> only the write is accepted; count rises to 1.
//  Flags: all registered, computed from next count, valid the cycle after the access.
//    - A write at cycle t clears EMPTY at t+1.
//    - A read at t+1 is legal; RAM data was written on edge t.
//  Errors:
//    - OVERFLOW <= WE & FULL; UNDERFLOW <= RE & EMPTY; each registered, 1-cycle pulse.
//    - Pointers and count are unaffected.
//  DVLD: rd_ok delayed by exactly RD_LAT cycles through a shift register.
//    - A read accepted at cycle t gives DVLD = 1 at t+RD_LAT, aligned with RAM RDATA.
//  Read-during-write to the same address cannot occur; no bypass logic.
// STRUCTURE
//  Shared package (fifo_ctrl_pkg):
//    - clog2 function
//    - DEPTH/RD_LAT legality checks (elaboration error if DEPTH is not 2^AWIDTH or RD_LAT not in {1,2})
//  Sub-module fifo_rd_vld_pipe (parameter RD_LAT):
//    - holds the rd_ok -> DVLD shift register, async cleared by RESET
//  Pointers, count and flag registers stay in this module.
// TESTING
//  1 Reset then idle: EMPTY=1, AEMPTY=1, WRCNT=0, all other outputs 0, no RAM_WEN/RAM_REN.
//  2 128 consecutive writes -> WRCNT=128, FULL=1 the cycle after the 128th write, AFULL=1 from count 120.
//    A 129th WE gives OVERFLOW for 1 cycle, RAM_WEN=0, WRCNT stays 128.
//  3 Write 0xA5 at addr 0, then RE next cycle:
//    RAM_RADDR=0, RAM_REN=1, DVLD exactly RD_LAT cycles later (test RD_LAT=1 and 2).
//    RE while empty -> UNDERFLOW pulse, no RAM_REN.
//  4 At FULL drive WE=RE=1 for 1 cycle: read only accepted, WRCNT=127, FULL=0.
//    At EMPTY drive WE=RE=1: write only accepted, WRCNT=1.
//  5 Wrap-around: 300 random WE/RE cycles against a reference queue model.
//    Pointers wrap 127->0, data order preserved, WRCNT always matches the model.
//  6 Assert RESET with 2 reads in flight and WRCNT=50: DVLD never fires afterwards.
//    All state returns to reset values immediately.

Source files
------------

// File: rtl/fifo_ctrl_pkg.sv
// Shared definitions for the single-clock LSRAM FIFO controller: sizing helpers,
// parameter legality checks and the registered status-flag bundle.
package fifo_ctrl_pkg;

    typedef struct packed {
        logic full;
        logic empty;
        logic afull;
        logic aempty;
    } fifo_flags_t;

    localparam fifo_flags_t FLAGS_RESET = '{full: 1'b0, empty: 1'b1, afull: 1'b0, aempty: 1'b1};

    function automatic int clog2(input int value);
        int result;
        result = 0;
        while ((1 << result) < value) begin
            result = result + 1;
        end
        return result;
    endfunction

    function automatic bit depth_ok(input int depth, input int awidth);
        return (depth > 1) && ((1 << clog2(depth)) == depth) && (clog2(depth) == awidth);
    endfunction

    function automatic bit rd_lat_ok(input int rd_lat);
        return (rd_lat == 1) || (rd_lat == 2);
    endfunction

endpackage

// File: rtl/fifo_rd_vld_pipe.sv
// Delays the accepted-read strobe by the RAM read latency so DVLD lines up with RDATA.
module fifo_rd_vld_pipe #(
    parameter int RD_LAT = 2
) (
    input  logic clk,
    input  logic rst,
    input  logic rd_ok,
    output logic dvld
);

    logic [RD_LAT-1:0] vld_pipe_q;
    logic [RD_LAT-1:0] vld_pipe_d;

    always_comb begin
        vld_pipe_d    = '0;
        vld_pipe_d[0] = rd_ok;
        for (int i = 1; i < RD_LAT; i++) begin
            vld_pipe_d[i] = vld_pipe_q[i-1];
        end
    end

    // Clearing on reset drops reads still in flight so they never raise DVLD.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            vld_pipe_q <= '0;
        end else begin
            vld_pipe_q <= vld_pipe_d;
        end
    end

    assign dvld = vld_pipe_q[RD_LAT-1];

endmodule

// File: rtl/fifo_sync_ram_ctrl.sv
// Single-clock FIFO controller for an external dual-port LSRAM: pointers, occupancy,
// status flags, error pulses and read-data-valid alignment.
module fifo_sync_ram_ctrl
    import fifo_ctrl_pkg::*;
#(
    parameter int DEPTH     = 128,
    parameter int AWIDTH    = 7,
    parameter int RD_LAT    = 2,
    parameter int AFULL_TH  = 120,
    parameter int AEMPTY_TH = 8
) (
    input  logic              CLOCK,
    input  logic              RESET,
    input  logic              WE,
    input  logic              RE,
    output logic [AWIDTH-1:0] RAM_WADDR,
    output logic              RAM_WEN,
    output logic [AWIDTH-1:0] RAM_RADDR,
    output logic              RAM_REN,
    output logic              DVLD,
    output logic              FULL,
    output logic              EMPTY,
    output logic              AFULL,
    output logic              AEMPTY,
    output logic [AWIDTH:0]   WRCNT,
    output logic              OVERFLOW,
    output logic              UNDERFLOW
);

    generate
        if (!depth_ok(DEPTH, AWIDTH)) begin : g_bad_depth
            $error("fifo_sync_ram_ctrl: DEPTH must be a power of 2 equal to 2**AWIDTH");
        end
        if (!rd_lat_ok(RD_LAT)) begin : g_bad_rd_lat
            $error("fifo_sync_ram_ctrl: RD_LAT must be 1 or 2");
        end
    endgenerate

    localparam logic [AWIDTH:0] DEPTH_C     = (AWIDTH+1)'(DEPTH);
    localparam logic [AWIDTH:0] AFULL_TH_C  = (AWIDTH+1)'(AFULL_TH);
    localparam logic [AWIDTH:0] AEMPTY_TH_C = (AWIDTH+1)'(AEMPTY_TH);

    logic [AWIDTH-1:0] wptr_q, wptr_d;
    logic [AWIDTH-1:0] rptr_q, rptr_d;
    logic [AWIDTH:0]   count_q, count_d;
    fifo_flags_t       flags_q, flags_d;
    logic              overflow_q, overflow_d;
    logic              underflow_q, underflow_d;
    logic              wr_ok;
    logic              rd_ok;

    // Acceptance uses the registered flags, so at full a simultaneous write is
    // refused while the read goes through, and the reverse at empty.
    always_comb begin
        wr_ok         = WE & ~flags_q.full;
        rd_ok         = RE & ~flags_q.empty;
        wptr_d        = wptr_q + AWIDTH'(wr_ok);
        rptr_d        = rptr_q + AWIDTH'(rd_ok);
        count_d       = count_q + (AWIDTH+1)'(wr_ok) - (AWIDTH+1)'(rd_ok);
        flags_d       = FLAGS_RESET;
        flags_d.full  = (count_d == DEPTH_C);
        flags_d.empty = (count_d == '0);
        flags_d.afull = (count_d >= AFULL_TH_C);
        flags_d.aempty = (count_d <= AEMPTY_TH_C);
        overflow_d    = WE & flags_q.full;
        underflow_d   = RE & flags_q.empty;
    end

    always_ff @(posedge CLOCK or posedge RESET) begin
        if (RESET) begin
            wptr_q      <= '0;
            rptr_q      <= '0;
            count_q     <= '0;
            flags_q     <= FLAGS_RESET;
            overflow_q  <= 1'b0;
            underflow_q <= 1'b0;
        end else begin
            wptr_q      <= wptr_d;
            rptr_q      <= rptr_d;
            count_q     <= count_d;
            flags_q     <= flags_d;
            overflow_q  <= overflow_d;
            underflow_q <= underflow_d;
        end
    end

    fifo_rd_vld_pipe #(
        .RD_LAT (RD_LAT)
    ) u_rd_vld_pipe (
        .clk   (CLOCK),
        .rst   (RESET),
        .rd_ok (rd_ok),
        .dvld  (DVLD)
    );

    assign RAM_WADDR = wptr_q;
    assign RAM_RADDR = rptr_q;
    assign RAM_WEN   = wr_ok;
    assign RAM_REN   = rd_ok;
    assign FULL      = flags_q.full;
    assign EMPTY     = flags_q.empty;
    assign AFULL     = flags_q.afull;
    assign AEMPTY    = flags_q.aempty;
    assign WRCNT     = count_q;
    assign OVERFLOW  = overflow_q;
    assign UNDERFLOW = underflow_q;

endmodule
